cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. It sits beside the M stage and takes the exception code and branch-delay flag carried down from the E-stage exception detector, together with the six hardware interrupt lines. It arbitrates interrupts against synchronous exceptions, records SR/Cause/EPC state, and raises the pipeline flush/redirect request. It also serves `mfc0`, `mtc0` and `eret` from the M stage.

## Interface

Parameters:
- `PRID`, default 32'h0000_4D49, read-only value of PRId (reg 15)

Ports:
- `clk` in 1: pipeline clock
- `reset` in 1: asynchronous, active-high
- `pc_m` in 32: PC of the M-stage instruction; bubbles carry the PC of the slot they replace
- `bd_m` in 1: M-stage instruction is in a branch delay slot
- `exccode_m` in 5: M-stage exception code; 0 = none
- `hwint` in 6: hardware interrupt lines, level-sensitive
- `we` in 1: `mtc0` in M
- `a1` in 5: `mfc0` read register number
- `a2` in 5: `mtc0` write register number
- `din` in 32: `mtc0` write data
- `eret_m` in 1: `eret` in M
- `dout` out 32: `mfc0` read data
- `epc_out` out 32: eret target
- `req` out 1: exception/interrupt taken this cycle; pipeline flushes F–M and redirects to 32'h0000_4180
- `exl` out 1: current SR.EXL

## Operation

Registers:
- SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0; software-read-only.
- EPC (14): 32 bits, bits [1:0] always 0.
- PRId (15): constant `PRID`.

State: EXL is the two-state machine.
- RUN (EXL=0) goes to HANDLER (EXL=1) on `req`.
- HANDLER goes back to RUN on `eret_m`, or on an `mtc0` that clears SR bit 1.

Request logic (combinational):
- `int_req = |(hwint & SR.IM) & SR.IE & ~SR.EXL`
- `exc_req = (exccode_m != 0) & ~SR.EXL`
- `req = int_req | exc_req`
- Interrupt has priority over a simultaneous exception.

Clock edge with `req`=1:
- EXL <= 1.
- ExcCode <= `int_req` ? 0 : `exccode_m`.
- BD <= `bd_m`.
- EPC <= (`bd_m` ? `pc_m` − 4 : `pc_m`) with [1:0] forced to 0.
- `mtc0` and `eret_m` in the same cycle are discarded; the M instruction is the victim.

Clock edge with `req`=0:
- `we`: write SR (IM, EXL, IE bits only) or EPC (bits [31:2]) when `a2` = 12 or 14. Writes to Cause, PRId or other numbers are ignored.
- `eret_m`: EXL <= 0. If `we` targets SR in the same cycle, the `mtc0` value is written first and `eret` then clears EXL.

Every edge: Cause.IP <= `hwint`, independent of `req`.

Outputs:
- `dout` = register selected by `a1`. Numbers 12/13/14/15 return SR/Cause/EPC/PRId; any other number returns 0. No write-through.
- `epc_out` = `din` & ~3 when `we` & `a2`==14, else EPC. This bypass lets `mtc0 EPC; eret` work back to back.

## Timing

- `req` is combinational from inputs and the SR state, so it is valid in the same cycle the exception reaches M. All register updates land on the following edge.
- Reset (asynchronous): SR, Cause and EPC become 0, and `exl`=0. `req` is 0 while `exccode_m`=0. Reset mid-handler returns the block to RUN.
- While EXL=1, `req` is forced to 0. Nested exceptions and interrupts are masked and leave Cause.ExcCode, BD and EPC unchanged.
- `hwint` must be held until software acknowledges it; Cause.IP lags `hwint` by one cycle.
- `pc_m` − 4 uses 32-bit wrap-around: 0 − 4 = 32'hFFFF_FFFC.

## Test plan

- Reset, then SR=0: drive `exccode_m`=12 (Ov), `pc_m`=32'h3008, `bd_m`=0. Expect `req`=1 that cycle; after the edge EXL=1, Cause=32'h0000_0030, EPC=32'h3008.
- Delay-slot fault: `exccode_m`=4, `bd_m`=1, `pc_m`=32'h3010. Expect EPC=32'h300C, Cause.BD=1, ExcCode=4.
- `mtc0` SR=32'h0000_0401, then `hwint`=6'b000001 while `exccode_m`=5. Expect `req`=1 with ExcCode=0; the following cycle `dout`(a1=13) shows IP=1 and ExcCode=0.
- In HANDLER, drive `exccode_m`=10 and `hwint`=1. Expect `req`=0 and registers unchanged. Then `mtc0` EPC=32'h3021 with `eret_m` in the next cycle. Expect `epc_out`=32'h3020 during the write cycle, and EXL=0 after the `eret` edge.
- Same-cycle conflict: `we`, `a2`=12, `din`=0 with `exccode_m`=8. Expect `req`=1, SR.IE/IM unchanged, EXL=1.
- Assert `reset` while EXL=1 and EPC≠0. Expect SR, Cause and EPC = 0 immediately, before the next edge.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 exception/interrupt arbiter holding SR/Cause/EPC/PRId; ports clk, reset, M-stage pc/bd/exccode, hwint, mtc0 (we/a2/din), mfc0 (a1/dout), eret_m, epc_out, req, exl
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID = 32'h0000_4D49
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exccode_m,
  input  logic [5:0]  hwint,
  input  logic        we,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [31:0] din,
  input  logic        eret_m,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        req,
  output logic        exl
);
  logic [5:0]  im, ip;
  logic        ie, bd, exl_d, int_req, exc_req, wr_sr, wr_epc;
  logic [4:0]  exccode;
  logic [31:0] epc, epc_n, sr, cause;
  always_ff @(posedge clk or posedge reset)
    if (reset) exl <= 1'b0;
    else exl <= exl_d;
  always_comb begin
    exl_d = exl;
    if (req) exl_d = 1'b1;
    else begin
      if (wr_sr) exl_d = din[1];
      if (eret_m) exl_d = 1'b0;
    end
  end
  always_comb begin
    int_req = |(hwint & im) & ie & ~exl;
    exc_req = (exccode_m != 5'd0) & ~exl;
    req     = int_req | exc_req;
    wr_sr   = we & (a2 == 5'd12);
    wr_epc  = we & (a2 == 5'd14);
    epc_n   = (bd_m ? pc_m - 32'd4 : pc_m) & ~32'd3;
    sr      = {16'h0, im, 8'h0, exl, ie};
    cause   = {bd, 15'h0, ip, 3'b0, exccode, 2'b0};
    dout    = a1 == 5'd12 ? sr : a1 == 5'd13 ? cause : a1 == 5'd14 ? epc : a1 == 5'd15 ? PRID : 32'h0;
    epc_out = wr_epc ? din & ~32'd3 : epc;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      im      <= '0;
      ie      <= 1'b0;
      ip      <= '0;
      bd      <= 1'b0;
      exccode <= '0;
      epc     <= '0;
    end else begin
      ip <= hwint;
      if (req) begin
        bd      <= bd_m;
        exccode <= int_req ? 5'd0 : exccode_m;
        epc     <= epc_n;
      end else begin
        if (wr_sr) begin
          im <= din[15:10];
          ie <= din[0];
        end
        if (wr_epc) epc <= din & ~32'd3;
      end
    end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: directed self-checking bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;
  logic        clk = 0, reset = 1, bd_m = 0, we = 0, eret_m = 0;
  logic [31:0] pc_m = 0, din = 0;
  logic [4:0]  exccode_m = 0, a1 = 0, a2 = 0;
  logic [5:0]  hwint = 0;
  logic [31:0] dout, epc_out;
  logic        req, exl;
  int checks = 0, errors = 0;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .pc_m(pc_m), .bd_m(bd_m), .exccode_m(exccode_m),
    .hwint(hwint), .we(we), .a1(a1), .a2(a2), .din(din), .eret_m(eret_m),
    .dout(dout), .epc_out(epc_out), .req(req), .exl(exl)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bd_m = 0; we = 0; eret_m = 0; pc_m = 0; din = 0; exccode_m = 0; a2 = 0; hwint = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] v);
    a1 = r;
    #1;
    v = dout;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    #1;
    rd(12, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_sr got %h want %h", v, 32'h0); end
    rd(13, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cause got %h want %h", v, 32'h0); end
    rd(14, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_epc got %h want %h", v, 32'h0); end
    rd(15, v); checks++; if (v !== 32'h0000_4D49) begin errors++; $display("FAIL prid got %h want %h", v, 32'h0000_4D49); end
    rd(3, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped_reg got %h want %h", v, 32'h0); end
    checks++; if (exl !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL reset_exl_req got %b%b want 00", exl, req); end
    @(negedge clk); reset = 0;
  endtask

  task automatic leave_handler();
    @(negedge clk); idle(); eret_m = 1;
    step(); idle();
    checks++; if (exl !== 1'b0) begin errors++; $display("FAIL eret_exl got %b want 0", exl); end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    @(negedge clk); idle(); exccode_m = 12; pc_m = 32'h3008;
    #1; checks++; if (req !== 1'b1) begin errors++; $display("FAIL exc_req got %b want 1", req); end
    step(); idle();
    checks++; if (exl !== 1'b1) begin errors++; $display("FAIL exc_exl got %b want 1", exl); end
    rd(13, v); checks++; if (v !== 32'h0000_0030) begin errors++; $display("FAIL exc_cause got %h want %h", v, 32'h30); end
    rd(14, v); checks++; if (v !== 32'h0000_3008) begin errors++; $display("FAIL exc_epc got %h want %h", v, 32'h3008); end
    leave_handler();
  endtask

  task automatic test_delay_slot();
    logic [31:0] v;
    @(negedge clk); idle(); exccode_m = 4; bd_m = 1; pc_m = 32'h3010;
    #1; checks++; if (req !== 1'b1) begin errors++; $display("FAIL bd_req got %b want 1", req); end
    step(); idle();
    rd(14, v); checks++; if (v !== 32'h0000_300C) begin errors++; $display("FAIL bd_epc got %h want %h", v, 32'h300C); end
    rd(13, v); checks++; if (v !== 32'h8000_0010) begin errors++; $display("FAIL bd_cause got %h want %h", v, 32'h8000_0010); end
    leave_handler();
  endtask

  task automatic test_interrupt();
    logic [31:0] v;
    @(negedge clk); idle(); we = 1; a2 = 12; din = 32'h0000_0401;
    step(); idle();
    rd(12, v); checks++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL mtc0_sr got %h want %h", v, 32'h401); end
    @(negedge clk); idle(); hwint = 6'b000001; exccode_m = 5; pc_m = 32'h3018;
    #1; checks++; if (req !== 1'b1) begin errors++; $display("FAIL int_req got %b want 1", req); end
    step(); exccode_m = 0;
    rd(13, v); checks++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got %h want %h", v, 32'h400); end
    rd(14, v); checks++; if (v !== 32'h0000_3018) begin errors++; $display("FAIL int_epc got %h want %h", v, 32'h3018); end
  endtask

  task automatic test_masked_and_eret();
    logic [31:0] v;
    @(negedge clk); idle(); exccode_m = 10; hwint = 6'b000001; pc_m = 32'h5000; bd_m = 1;
    #1; checks++; if (req !== 1'b0) begin errors++; $display("FAIL masked_req got %b want 0", req); end
    step();
    rd(13, v); checks++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL masked_cause got %h want %h", v, 32'h400); end
    rd(14, v); checks++; if (v !== 32'h0000_3018) begin errors++; $display("FAIL masked_epc got %h want %h", v, 32'h3018); end
    @(negedge clk); idle(); we = 1; a2 = 14; din = 32'h0000_3021;
    #1; checks++; if (epc_out !== 32'h0000_3020) begin errors++; $display("FAIL epc_bypass got %h want %h", epc_out, 32'h3020); end
    step(); idle(); eret_m = 1;
    #1; checks++; if (epc_out !== 32'h0000_3020) begin errors++; $display("FAIL epc_out got %h want %h", epc_out, 32'h3020); end
    checks++; if (exl !== 1'b1) begin errors++; $display("FAIL pre_eret_exl got %b want 1", exl); end
    step(); idle();
    checks++; if (exl !== 1'b0) begin errors++; $display("FAIL b2b_eret_exl got %b want 0", exl); end
  endtask

  task automatic test_conflict();
    logic [31:0] v;
    @(negedge clk); idle(); we = 1; a2 = 12; din = 32'h0; exccode_m = 8; pc_m = 32'h3030;
    #1; checks++; if (req !== 1'b1) begin errors++; $display("FAIL conflict_req got %b want 1", req); end
    step(); idle();
    rd(12, v); checks++; if (v !== 32'h0000_0403) begin errors++; $display("FAIL conflict_sr got %h want %h", v, 32'h403); end
    rd(13, v); checks++; if (v !== 32'h0000_0020) begin errors++; $display("FAIL conflict_cause got %h want %h", v, 32'h20); end
    @(negedge clk); idle(); we = 1; a2 = 12; din = 32'h0000_0400;
    step(); idle();
    rd(12, v); checks++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL mtc0_clr_exl got %h want %h", v, 32'h400); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    @(negedge clk); idle(); exccode_m = 4; bd_m = 1; pc_m = 32'h0;
    step(); idle();
    rd(14, v); checks++; if (v !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_epc got %h want %h", v, 32'hFFFF_FFFC); end
    @(negedge clk); idle(); we = 1; a2 = 13; din = 32'hFFFF_FFFF;
    step(); idle();
    rd(13, v); checks++; if (v !== 32'h8000_0010) begin errors++; $display("FAIL cause_ro got %h want %h", v, 32'h8000_0010); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    @(negedge clk); idle(); eret_m = 1; we = 1; a2 = 12; din = 32'h0000_0403;
    step(); idle();
    rd(12, v); checks++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL eret_mtc0_sr got %h want %h", v, 32'h401); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    @(negedge clk); idle(); exccode_m = 12; pc_m = 32'h3040;
    step(); idle();
    rd(14, v); checks++; if (v !== 32'h0000_3040 || exl !== 1'b1) begin errors++; $display("FAIL pre_reset got epc %h exl %b want 3040 1", v, exl); end
    @(negedge clk); #2; reset = 1;
    rd(12, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL async_sr got %h want 0", v); end
    rd(13, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL async_cause got %h want 0", v); end
    rd(14, v); checks++; if (v !== 32'h0) begin errors++; $display("FAIL async_epc got %h want 0", v); end
    checks++; if (exl !== 1'b0) begin errors++; $display("FAIL async_exl got %b want 0", exl); end
    @(negedge clk); reset = 0;
  endtask

  initial begin
    test_reset();
    test_exception();
    test_delay_slot();
    test_interrupt();
    test_masked_and_eret();
    test_conflict();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
